dmem_rmw_ctrl: RTL and testbench

Parametrised data-memory access controller between the MEM stage and a full-width-only data memory. It turns sub-word stores (byte/half/word narrower than the bus) into read-modify-write sequences. It performs lane extraction and sign/zero extension for loads. Pipeline and memory sides both use valid/ready handshakes, so memory wait states are tolerated; it supersedes the fixed 32-bit single-cycle-replay scheme.

---
 rtl/dmem_rmw_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_rmw_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory access controller: sub-word stores become read-modify-write, loads get lane extraction/extension.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_rmw_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_maskMode,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dmem_valid,
  input  logic              dmem_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_memRead,
  output logic              dmem_memWrite,
  output logic [DATA_W-1:0] dmem_writeData,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_readData
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  state_t              state;
  logic                cap_write;
  logic                cap_sext;
  logic [OFF_W-1:0]    cap_off;
  logic [3:0]          cap_size;
  logic [DATA_W-1:0]   cap_wdata;

  logic [1:0]          eff_mode;
  logic [3:0]          acc_size;
  logic [OFF_W-1:0]    off_raw;
  logic [OFF_W-1:0]    off_al;
  logic                accept;
  logic                trap;

  always_comb begin
    eff_mode = req_maskMode;
    if (DATA_W == 32 && req_maskMode == 2'd3) eff_mode = 2'd2;
  end

  assign acc_size = 4'd1 << eff_mode;
  assign off_raw  = req_addr[OFF_W-1:0];
  assign off_al   = off_raw & ~OFF_W'(acc_size - 4'd1);
  assign accept   = req_valid & req_ready & (req_read | req_write);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = (off_raw != off_al);
`else
  assign trap     = 1'b0;
  assign resp_err = 1'b0;
`endif

  // Byte lanes [off, off+size) of word replaced by the low bytes of data.
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] word,
                                                   input logic [DATA_W-1:0] data,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [3:0]        size);
    logic [DATA_W-1:0] m;
    int unsigned o, s;
    o = 32'(off);
    s = 32'(size);
    m = ({DATA_W{1'b1}} >> (DATA_W - s * 8)) << (o * 8);
    return (word & ~m) | ((data << (o * 8)) & m);
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] word,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [3:0]        size,
                                                input logic              sext);
    logic [DATA_W-1:0] sh, fm;
    int unsigned o, s;
    o  = 32'(off);
    s  = 32'(size);
    sh = word >> (o * 8);
    fm = {DATA_W{1'b1}} >> (DATA_W - s * 8);
    if (sext && |(sh & (DATA_W'(1) << (s * 8 - 1))))
      return sh | ~fm;
    return sh & fm;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      resp_err       <= 1'b0;
`endif
      dmem_valid     <= 1'b0;
      dmem_addr      <= '0;
      dmem_memRead   <= 1'b0;
      dmem_memWrite  <= 1'b0;
      dmem_writeData <= '0;
      cap_write      <= 1'b0;
      cap_sext       <= 1'b0;
      cap_off        <= '0;
      cap_size       <= '0;
      cap_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            cap_write <= req_write;
            cap_sext  <= req_sext;
            cap_off   <= off_al;
            cap_size  <= acc_size;
            cap_wdata <= req_wdata;
            dmem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (trap) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
              resp_err   <= 1'b1;
`endif
            end else if (req_write && 32'(acc_size) == NB) begin
              state          <= WR_REQ;
              dmem_valid     <= 1'b1;
              dmem_memWrite  <= 1'b1;
              dmem_writeData <= req_wdata;
            end else begin
              state        <= RD_REQ;
              dmem_valid   <= 1'b1;
              dmem_memRead <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (dmem_ready) begin
            state        <= RD_WAIT;
            dmem_valid   <= 1'b0;
            dmem_memRead <= 1'b0;
          end
        end
        RD_WAIT: begin
          // Read word is folded straight into the write data or the response register.
          if (dmem_rvalid) begin
            if (cap_write) begin
              state          <= WR_REQ;
              dmem_valid     <= 1'b1;
              dmem_memWrite  <= 1'b1;
              dmem_writeData <= merge_word(dmem_readData, cap_wdata, cap_off, cap_size);
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= extract(dmem_readData, cap_off, cap_size, cap_sext);
            end
          end
        end
        WR_REQ: begin
          if (dmem_ready) begin
            state         <= RESP;
            dmem_valid    <= 1'b0;
            dmem_memWrite <= 1'b0;
            resp_valid    <= 1'b1;
            resp_rdata    <= '0;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
          resp_err   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Scoreboard bench for dmem_rmw_ctrl: stimulus pushes expected memory traffic and responses, monitors pop and compare.
module tb_dmem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_read, req_write, req_sext;
  logic [1:0]  req_maskMode;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dmem_valid, dmem_ready, dmem_memRead, dmem_memWrite, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_writeData, dmem_readData;

  int total = 0;
  int bad   = 0;
  int rd_delay = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [31:0] rdata; logic err;} resp_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  resp_t       exp_resp[$];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  dmem_rmw_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_write(req_write),
    .req_maskMode(req_maskMode), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_memRead(dmem_memRead), .dmem_memWrite(dmem_memWrite), .dmem_writeData(dmem_writeData),
    .dmem_rvalid(dmem_rvalid), .dmem_readData(dmem_readData)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic expect_op(input logic rd, input logic [31:0] waddr, input logic wr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    wr_t w;
    resp_t r;
    if (rd) exp_rd.push_back(waddr);
    if (wr) begin
      w.addr = waddr;
      w.data = wdata;
      exp_wr.push_back(w);
    end
    r.rdata = rdata;
    r.err   = err;
    exp_resp.push_back(r);
  endtask

  task automatic send(input logic rd, input logic wr, input logic [1:0] mode, input logic sx,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = rd; req_write = wr; req_maskMode = mode;
    req_sext = sx; req_addr = addr; req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 50);
    chk(name, 32'(n), 32'(lat));
  endtask

  // Memory read responder: rvalid follows the accepted read after rd_delay extra cycles.
  initial begin : responder
    logic [31:0] a;
    dmem_rvalid = 1'b0;
    dmem_readData = '0;
    forever begin
      @(negedge clk);
      if (dmem_valid === 1'b1 && dmem_ready && dmem_memRead === 1'b1) begin
        a = dmem_addr;
        @(posedge clk);
        repeat (rd_delay) @(posedge clk);
        #1;
        dmem_rvalid = 1'b1;
        dmem_readData = mem.exists(a) ? mem[a] : 32'h0;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
      end
    end
  end

  initial begin : mem_monitor
    wr_t w;
    logic [31:0] ra;
    forever begin
      @(negedge clk);
      if (dmem_valid === 1'b1 && dmem_ready && dmem_memWrite === 1'b1) begin
        if (exp_wr.size() == 0) chk("unexpected_write", dmem_addr, 32'hFFFFFFFF);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", dmem_addr, w.addr);
          chk("wr_data", dmem_writeData, w.data);
        end
        mem[dmem_addr] = dmem_writeData;
      end
      if (dmem_valid === 1'b1 && dmem_ready && dmem_memRead === 1'b1) begin
        if (exp_rd.size() == 0) chk("unexpected_read", dmem_addr, 32'hFFFFFFFF);
        else begin
          ra = exp_rd.pop_front();
          chk("rd_addr", dmem_addr, ra);
        end
      end
    end
  end

  initial begin : resp_monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", resp_rdata, 32'hFFFFFFFF);
        else begin
          r = exp_resp.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", 32'(resp_err), 32'(r.err));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_sext = 1'b0;
    req_maskMode = 2'd0; req_addr = '0; req_wdata = '0;
    dmem_ready = 1'b1;
    mem[32'h100] = 32'h11223344;
    mem[32'h140] = 32'h11223344;
    mem[32'h180] = 32'h1122F344;
    mem[32'h1C0] = 32'h11223344;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_dmem_valid", 32'(dmem_valid), 32'd0);
    chk("rst_cmds", {30'd0, dmem_memRead, dmem_memWrite}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_writeData, 32'd0);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full-word store: single write, no read.
    expect_op(1'b0, 32'h100, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    wait_resp("lat_sw", 2);

    mem[32'h100] = 32'h11223344;
    expect_op(1'b1, 32'h100, 1'b1, 32'hAA223344, 32'h0, 1'b0);
    send(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h000000AA);
    wait_resp("lat_sb", 4);

    expect_op(1'b1, 32'h140, 1'b1, 32'h55663344, 32'h0, 1'b0);
    send(1'b0, 1'b1, 2'd1, 1'b0, 32'h142, 32'h00005566);
    wait_resp("lat_sh", 4);

    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'hFFFFFFF3, 1'b0);
    send(1'b1, 1'b0, 2'd0, 1'b1, 32'h181, 32'h0);
    wait_resp("lat_lb", 3);

    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'h000000F3, 1'b0);
    send(1'b1, 1'b0, 2'd0, 1'b0, 32'h181, 32'h0);
    wait_resp("lat_lbu", 3);

    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'h00000044, 1'b0);
    send(1'b1, 1'b0, 2'd0, 1'b1, 32'h180, 32'h0);
    wait_resp("lat_lb_pos", 3);

    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'h00001122, 1'b0);
    send(1'b1, 1'b0, 2'd1, 1'b1, 32'h182, 32'h0);
    wait_resp("lat_lh", 3);

    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'hFFFFF344, 1'b0);
    send(1'b1, 1'b0, 2'd1, 1'b1, 32'h180, 32'h0);
    wait_resp("lat_lh_neg", 3);

    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'h1122F344, 1'b0);
    send(1'b1, 1'b0, 2'd2, 1'b1, 32'h180, 32'h0);
    wait_resp("lat_lw", 3);

    // Mode 3 on a 32-bit bus behaves as a word store.
    expect_op(1'b0, 32'h1C4, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
    send(1'b0, 1'b1, 2'd3, 1'b0, 32'h1C4, 32'hCAFEF00D);
    wait_resp("lat_sd32", 2);

    // Write has priority over read when both are set.
    mem[32'h1C8] = 32'h11223344;
    expect_op(1'b1, 32'h1C8, 1'b1, 32'h11223377, 32'h0, 1'b0);
    send(1'b1, 1'b1, 2'd0, 1'b0, 32'h1C8, 32'h00000077);
    wait_resp("lat_rw_prio", 4);

`ifdef DMEM_MISALIGN_TRAP_EN
    expect_op(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    send(1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h00005566);
    wait_resp("lat_trap", 1);
`else
    expect_op(1'b1, 32'h1C0, 1'b1, 32'h11225566, 32'h0, 1'b0);
    send(1'b0, 1'b1, 2'd1, 1'b0, 32'h1C1, 32'h00005566);
    wait_resp("lat_sh_misal", 4);

    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'h00001122, 1'b0);
    send(1'b1, 1'b0, 2'd1, 1'b0, 32'h183, 32'h0);
    wait_resp("lat_lh_misal", 3);
`endif

    // Request with neither read nor write: ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h100;
    repeat (3) begin
      @(negedge clk);
      chk("ignored_no_dmem", 32'(dmem_valid), 32'd0);
      chk("ignored_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Full store with memory stalling three cycles.
    dmem_ready = 1'b0;
    expect_op(1'b0, 32'h200, 1'b1, 32'h0BADF00D, 32'h0, 1'b0);
    send(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h0BADF00D);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 32'(dmem_valid), 32'd1);
      chk("stall_addr", dmem_addr, 32'h200);
      chk("stall_wdata", dmem_writeData, 32'h0BADF00D);
      chk("stall_cmd", {30'd0, dmem_memRead, dmem_memWrite}, 32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_no_resp", 32'(resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("stall_resp_wait", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("stall_resp", 32'(resp_valid), 32'd1);

    // Reset while waiting for read data; late rvalid must be ignored.
    rd_delay = 1;
    exp_rd.push_back(32'h180);
    send(1'b1, 1'b0, 2'd0, 1'b1, 32'h180, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid_seen", 32'(dmem_rvalid), 32'd1);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_dmem_valid", 32'(dmem_valid), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    rd_delay = 0;

    // Controller still usable after the mid-operation reset.
    expect_op(1'b1, 32'h180, 1'b0, 32'h0, 32'h000000F3, 1'b0);
    send(1'b1, 1'b0, 2'd0, 1'b0, 32'h181, 32'h0);
    wait_resp("lat_after_rst", 3);

    repeat (5) @(negedge clk);
    chk("left_resp", 32'(exp_resp.size()), 32'd0);
    chk("left_wr", 32'(exp_wr.size()), 32'd0);
    chk("left_rd", 32'(exp_rd.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
